// File: rtl/stream_to_mig_writer.sv
// rtl/stream_to_mig_writer.sv - packs a YUV pixel stream into 16-bit overlay words and writes one frame through a MIG user write port
//
// Optional feature macro: STREAM_WRITER_ROW_PAD_EN (word-align every row by flushing a half word at ROW_END).
// dtypei encoding: 0 = FRAME_START, 1 = ROW_END, 2 = PIXEL, 3 = FRAME_END.
// Overlay half word: {alpha[2:0], Y[7:1], C[7:2]}, C = U for even pixels and V for odd pixels.

module stream_to_mig_writer #(
  parameter int ADDR_WIDTH  = 26,
  parameter int BL_WIDTH    = 6,
  parameter int BURST_LEN   = 32,
  parameter int DTYPE_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  frame_addr,
  input  logic [2:0]             alpha,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [7:0]             data0i,
  input  logic [7:0]             data1i,
  input  logic [7:0]             data2i,
  output logic                   wr_en,
  output logic [31:0]            wr_data,
  output logic [3:0]             wr_mask,
  input  logic                   wr_full,
  output logic                   wr_cmd_en,
  output logic [BL_WIDTH-1:0]    wr_cmd_bl,
  output logic [ADDR_WIDTH-1:0]  wr_cmd_byte_addr,
  input  logic                   wr_cmd_full,
  output logic                   busy,
  output logic                   overflow,
  output logic [31:0]            words_written
);

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(0);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL       = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(3);

  localparam logic [BL_WIDTH-1:0]   FULL_BL     = BL_WIDTH'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(4 * BURST_LEN);
  localparam logic [31:0]           BURST_WORDS = 32'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                  state;
  logic                    phase;
  logic [15:0]             half;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [31:0]             pending;

  logic                    is_fs;
  logic                    is_re;
  logic                    is_pix;
  logic                    is_fe;
  logic [15:0]             even_half;
  logic [15:0]             odd_half;
  logic                    word_due;
  logic [31:0]             word_val;
  logic                    accept;
  logic                    drop;
  logic                    burst_issue;
  logic                    final_issue;
  logic                    drain_done;
  logic [31:0]             pending_next;
  logic                    unused_lsbs;

  // Chroma and luma LSBs are intentionally discarded by the overlay format.
  assign unused_lsbs = ^{data0i[0], data1i[1:0], data2i[1:0]};

  assign wr_mask = 4'b0000;
  assign busy    = (state != IDLE);

  // Decode the stream beat and decide whether a word is due, accepted, and whether a command can go out.
  always_comb begin
    is_fs     = dvi && (dtypei == DT_FRAME_START);
    is_re     = dvi && (dtypei == DT_ROW_END);
    is_pix    = dvi && (dtypei == DT_PIXEL);
    is_fe     = dvi && (dtypei == DT_FRAME_END);
    even_half = {alpha, data0i[7:1], data1i[7:2]};
    odd_half  = {alpha, data0i[7:1], data2i[7:2]};
    word_due  = 1'b0;
    word_val  = {odd_half, half};
    case (state)
      CAPTURE: begin
        if (is_pix && phase) word_due = 1'b1;
`ifdef STREAM_WRITER_ROW_PAD_EN
        if (is_re && phase) begin
          word_due = 1'b1;
          word_val = {16'h0000, half};
        end
`endif
      end
      DRAIN: begin
        if (phase) begin
          word_due = 1'b1;
          word_val = {16'h0000, half};
        end
      end
      default: begin
        word_due = 1'b0;
      end
    endcase
    accept       = word_due && !wr_full;
    drop         = word_due && wr_full;
    burst_issue  = (state != IDLE) && (pending >= BURST_WORDS) && !wr_cmd_full;
    final_issue  = (state == DRAIN) && !phase && (pending != 32'd0) &&
                   (pending < BURST_WORDS) && !wr_cmd_full;
    drain_done   = (state == DRAIN) && !phase && ((pending == 32'd0) || final_issue);
    pending_next = pending + {31'b0, accept} - (burst_issue ? BURST_WORDS : 32'd0);
  end

  // Frame FSM: packing, data pushes, burst command issue and bookkeeping.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state            <= IDLE;
      phase            <= 1'b0;
      half             <= 16'h0000;
      addr             <= '0;
      pending          <= 32'd0;
      wr_en            <= 1'b0;
      wr_data          <= 32'd0;
      wr_cmd_en        <= 1'b0;
      wr_cmd_bl        <= '0;
      wr_cmd_byte_addr <= '0;
      overflow         <= 1'b0;
      words_written    <= 32'd0;
    end else if (!enable) begin
      // Abandon the frame: nothing owed is written, only the sticky flag survives.
      state            <= IDLE;
      phase            <= 1'b0;
      half             <= 16'h0000;
      addr             <= '0;
      pending          <= 32'd0;
      wr_en            <= 1'b0;
      wr_data          <= 32'd0;
      wr_cmd_en        <= 1'b0;
      wr_cmd_bl        <= '0;
      wr_cmd_byte_addr <= '0;
      words_written    <= 32'd0;
    end else begin
      wr_en     <= accept;
      wr_cmd_en <= 1'b0;
      if (accept) wr_data <= word_val;
      if (drop) overflow <= 1'b1;
      words_written <= words_written + {31'b0, accept};
      pending       <= pending_next;

      if (burst_issue) begin
        wr_cmd_en        <= 1'b1;
        wr_cmd_bl        <= FULL_BL;
        wr_cmd_byte_addr <= addr;
        addr             <= addr + BURST_BYTES;
      end else if (final_issue) begin
        wr_cmd_en        <= 1'b1;
        wr_cmd_bl        <= BL_WIDTH'(pending - 32'd1);
        wr_cmd_byte_addr <= addr;
        addr             <= addr + ADDR_WIDTH'(pending << 2);
        pending          <= 32'd0;
      end

      case (state)
        IDLE: begin
          if (is_fs) begin
            addr          <= frame_addr;
            phase         <= 1'b0;
            half          <= 16'h0000;
            pending       <= 32'd0;
            words_written <= 32'd0;
            overflow      <= 1'b0;
            state         <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (is_pix) begin
            phase <= ~phase;
            if (!phase) begin
              half          <= even_half;
              wr_data[15:0] <= even_half;
            end
          end
`ifdef STREAM_WRITER_ROW_PAD_EN
          if (is_re && phase) phase <= 1'b0;
`endif
          if (is_fs) overflow <= 1'b1;
          if (is_fe) state <= DRAIN;
        end
        DRAIN: begin
          phase <= 1'b0;
          if (drain_done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_mig_writer.sv
// tb/tb_stream_to_mig_writer.sv - self-checking bench for stream_to_mig_writer against a frame-level packing model

module tb_stream_to_mig_writer;

  localparam logic [1:0] DT_FS  = 2'd0;
  localparam logic [1:0] DT_RE  = 2'd1;
  localparam logic [1:0] DT_PIX = 2'd2;
  localparam logic [1:0] DT_FE  = 2'd3;

  logic        clk;
  logic        resetb;
  logic        enable;
  logic [25:0] frame_addr;
  logic [2:0]  alpha;
  logic        dvi;
  logic [1:0]  dtypei;
  logic [7:0]  data0i, data1i, data2i;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full;
  logic        wr_cmd_en;
  logic [5:0]  wr_cmd_bl;
  logic [25:0] wr_cmd_byte_addr;
  logic        wr_cmd_full;
  logic        busy;
  logic        overflow;
  logic [31:0] words_written;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_words[$];
  logic [31:0] exp_cmds[$];
  logic [31:0] cmd_log[$];
  int          model_n;
  logic        cf_q = 1'b0;
  logic        stall_arm = 1'b0;

  stream_to_mig_writer dut (
    .clk(clk), .resetb(resetb), .enable(enable), .frame_addr(frame_addr), .alpha(alpha),
    .dvi(dvi), .dtypei(dtypei), .data0i(data0i), .data1i(data1i), .data2i(data2i),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .wr_cmd_en(wr_cmd_en), .wr_cmd_bl(wr_cmd_bl), .wr_cmd_byte_addr(wr_cmd_byte_addr),
    .wr_cmd_full(wr_cmd_full), .busy(busy), .overflow(overflow), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] py(input int r, input int c);
    return 8'(r * 29 + c * 7 + 3);
  endfunction
  function automatic logic [7:0] pu(input int r, input int c);
    return 8'(r * 13 + c * 31 + 100);
  endfunction
  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(c * 53 + r * 5 + 9);
  endfunction

  // Apply one stream beat and advance to the next falling edge.
  task automatic cyc(input logic v, input logic [1:0] dt, input logic [7:0] y, input logic [7:0] u,
                     input logic [7:0] w, input logic full);
    dvi = v; dtypei = dt; data0i = y; data1i = u; data2i = w; wr_full = full;
    @(negedge clk);
  endtask

  // Capture previous-edge command-full so a command issued against a full FIFO is caught.
  initial forever begin
    @(posedge clk);
    cf_q = wr_cmd_full;
  end

  // Holds the command FIFO full for 10 cycles once the first burst is due.
  initial begin
    int  left;
    bit  used;
    left = 0; used = 0; wr_cmd_full = 1'b0;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        left--;
        if (left == 0) wr_cmd_full = 1'b0;
      end else if (stall_arm && !used && words_written == 32'd32) begin
        wr_cmd_full = 1'b1;
        left = 10;
        used = 1;
      end
    end
  end

  // Scoreboard: every pushed word and command must match the model, in order.
  initial forever begin
    @(negedge clk);
    if (resetb) begin
      if (wr_en) begin
        if (exp_words.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_wr_en: got data %0h want no push", wr_data);
        end else begin
          check("wr_data", wr_data, exp_words.pop_front());
          check("wr_mask", wr_mask, 4'b0000);
        end
      end
      if (wr_cmd_en) begin
        cmd_log.push_back({wr_cmd_byte_addr, wr_cmd_bl});
        check("cmd_while_full", cf_q, 1'b0);
        if (exp_cmds.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_cmd: got %0h want no command", {wr_cmd_byte_addr, wr_cmd_bl});
        end else begin
          check("cmd", {wr_cmd_byte_addr, wr_cmd_bl}, exp_cmds.pop_front());
        end
      end
    end
  end

  task automatic run_frame(input int rows, input int cols, input logic [25:0] faddr, input logic [2:0] al,
                           input int da, input int db, input int stop, input logic exp_ovf);
    bit          ph;
    int          slot;
    int          n;
    int          k;
    bit          done;
    logic [15:0] lo;
    logic [7:0]  y, u, v;
    logic        full;
    // Model: pack pixel pairs in raster order, then cut commands into 32-word bursts.
    ph = 0; slot = 0; n = 0; lo = 16'h0; done = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (stop >= 0 && slot >= stop) done = 1;
        if (!done) begin
          y = py(r, c); u = pu(r, c); v = pv(r, c);
          if (!ph) begin
            lo = {al, y[7:1], u[7:2]};
            ph = 1;
          end else begin
            if (slot != da && slot != db) begin exp_words.push_back({al, y[7:1], v[7:2], lo}); n++; end
            slot++;
            ph = 0;
          end
        end
      end
`ifdef STREAM_WRITER_ROW_PAD_EN
      if (!done && ph) begin
        if (slot != da && slot != db) begin exp_words.push_back({16'h0, lo}); n++; end
        slot++;
        ph = 0;
      end
`endif
    end
    if (stop < 0 && ph) begin
      exp_words.push_back({16'h0, lo});
      n++;
    end
    for (int i = 0; i < n / 32; i++) exp_cmds.push_back({faddr + 26'(128 * i), 6'd31});
    if (stop < 0 && (n % 32) != 0) exp_cmds.push_back({faddr + 26'(128 * (n / 32)), 6'((n % 32) - 1)});
    model_n = n;

    // Drive the frame.
    alpha = al; frame_addr = faddr;
    cyc(1, DT_FS, 8'h0, 8'h0, 8'h0, 1'b0);
    check("ovf_clear_at_fs", overflow, 1'b0);
    check("busy_after_fs", busy, 1'b1);
    ph = 0; slot = 0; done = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (!done) begin
          full = ph && (slot == da || slot == db);
          cyc(1, DT_PIX, py(r, c), pu(r, c), pv(r, c), full);
          if (ph) slot++;
          ph = ~ph;
          if (stop >= 0 && slot >= stop) done = 1;
        end
      end
      if (!done) begin
        full = 1'b0;
`ifdef STREAM_WRITER_ROW_PAD_EN
        full = ph && (slot == da || slot == db);
`endif
        cyc(1, DT_RE, 8'h0, 8'h0, 8'h0, full);
`ifdef STREAM_WRITER_ROW_PAD_EN
        if (ph) begin slot++; ph = 0; end
`endif
        cyc(0, DT_PIX, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      end
    end
    if (stop < 0) begin
      cyc(1, DT_FE, 8'h0, 8'h0, 8'h0, 1'b0);
      k = 0;
      while (busy && k < 400) begin
        cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);
        k++;
      end
      check("drain_timeout", k < 400, 1'b1);
      repeat (3) cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);
      check("words_written", words_written, n);
      check("overflow", overflow, exp_ovf);
    end else begin
      enable = 1'b0;
      cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);
      check("busy_after_disable", busy, 1'b0);
      check("ww_after_disable", words_written, 32'd0);
      repeat (10) cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);
      enable = 1'b1;
    end
    check("busy_end", busy, 1'b0);
    check("words_left", exp_words.size(), 0);
    check("cmds_left", exp_cmds.size(), 0);
  endtask

  initial begin
    int base;
    resetb = 1'b0; enable = 1'b0; frame_addr = 26'h0; alpha = 3'h0;
    dvi = 1'b0; dtypei = DT_PIX; data0i = 8'h0; data1i = 8'h0; data2i = 8'h0; wr_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_cmd_en", wr_cmd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_words", words_written, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_cmd", {wr_cmd_byte_addr, wr_cmd_bl}, 32'd0);
    resetb = 1'b1; enable = 1'b1;
    cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);

    // Pixel pair with hand-packed word, 1-cycle latency.
    exp_words.push_back(32'hA801B03F);
    exp_cmds.push_back({26'h40, 6'd0});
    alpha = 3'd5; frame_addr = 26'h40;
    cyc(1, DT_FS, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(1, DT_PIX, 8'h81, 8'hFC, 8'h00, 1'b0);
    cyc(1, DT_PIX, 8'h40, 8'h00, 8'h04, 1'b0);
    check("pair_wr_en_latency", wr_en, 1'b1);
    check("pair_wr_data", wr_data, 32'hA801B03F);
    cyc(1, DT_FE, 8'h0, 8'h0, 8'h0, 1'b0);
    repeat (5) cyc(0, DT_PIX, 8'h0, 8'h0, 8'h0, 1'b0);
    check("pair_words", words_written, 32'd1);
    check("pair_busy", busy, 1'b0);

    // 4x16 frame: one full burst.
    base = cmd_log.size();
    run_frame(4, 16, 26'h100, 3'd7, -1, -1, -1, 1'b0);
    check("f4x16_words", words_written, 32'd32);
    check("f4x16_ncmd", cmd_log.size() - base, 1);
    if (cmd_log.size() > base) check("f4x16_cmd", cmd_log[base], {26'h100, 6'd31});

    // 3x3 frame: odd-width rows.
    base = cmd_log.size();
    run_frame(3, 3, 26'h300, 3'd3, -1, -1, -1, 1'b0);
`ifdef STREAM_WRITER_ROW_PAD_EN
    check("f3x3_words", words_written, 32'd6);
    if (cmd_log.size() > base) check("f3x3_cmd", cmd_log[base], {26'h300, 6'd5});
`else
    check("f3x3_words", words_written, 32'd5);
    if (cmd_log.size() > base) check("f3x3_cmd", cmd_log[base], {26'h300, 6'd4});
`endif

    // 80-word frame with the command FIFO full at the first burst.
    base = cmd_log.size();
    stall_arm = 1'b1;
    run_frame(5, 32, 26'h100, 3'd1, -1, -1, -1, 1'b0);
    stall_arm = 1'b0;
    check("f80_words", words_written, 32'd80);
    check("f80_ncmd", cmd_log.size() - base, 3);
    if (cmd_log.size() >= base + 3) begin
      check("f80_cmd0", cmd_log[base],     {26'h100, 6'd31});
      check("f80_cmd1", cmd_log[base + 1], {26'h180, 6'd31});
      check("f80_cmd2", cmd_log[base + 2], {26'h200, 6'd15});
    end

    // Two word slots dropped by a full data FIFO.
    base = cmd_log.size();
    run_frame(4, 8, 26'h400, 3'd2, 3, 9, -1, 1'b1);
    check("ovf_words", words_written, 32'd14);
    if (cmd_log.size() > base) check("ovf_cmd", cmd_log[base], {26'h400, 6'd13});

    // Enable dropped after 40 words, then a fresh frame at a new address.
    run_frame(4, 32, 26'h1000, 3'd4, -1, -1, 40, 1'b0);
    check("ovf_kept_after_disable", overflow, 1'b0);
    base = cmd_log.size();
    run_frame(2, 4, 26'h2000, 3'd6, -1, -1, -1, 1'b0);
    check("new_frame_words", words_written, 32'd4);
    if (cmd_log.size() > base) check("new_frame_cmd", cmd_log[base], {26'h2000, 6'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
